// File: rtl/true_dual_port_ram_pkg.sv
// Shared defaults and rw mode encodings for the true dual-port RAM.
package true_dual_port_ram_pkg;

  localparam int LENGTH_DEF   = 8;
  localparam int LOCATION_DEF = 16;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Address width for a given depth; a single-word RAM still gets one address bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/true_dual_port_ram_if.sv
// Port bundle for true_dual_port_ram: two independent read/write ports A and B.
interface true_dual_port_ram_if
  import true_dual_port_ram_pkg::*;
#(
  parameter int length   = LENGTH_DEF,
  parameter int location = LOCATION_DEF
);

  localparam int AW = addr_width(location);

  // No handshake: each port acts on every rising clk edge according to its rw bit.
  logic              a_rw;
  logic              b_rw;
  logic [AW-1:0]     a_w_addr;
  logic [AW-1:0]     b_w_addr;
  logic [AW-1:0]     a_r_addr;
  logic [AW-1:0]     b_r_addr;
  logic [length-1:0] a_indata;
  logic [length-1:0] b_indata;
  logic [length-1:0] a_outdata;
  logic [length-1:0] b_outdata;

  modport master (
    output a_rw, b_rw, a_w_addr, b_w_addr, a_r_addr, b_r_addr, a_indata, b_indata,
    input  a_outdata, b_outdata
  );

  modport slave (
    input  a_rw, b_rw, a_w_addr, b_w_addr, a_r_addr, b_r_addr, a_indata, b_indata,
    output a_outdata, b_outdata
  );

endinterface

// File: rtl/tdpram_read_port.sv
// One port's registered read path; with TDPRAM_BYPASS_EN defined the other
// port's same-cycle write data is forwarded on an address match.
module tdpram_read_port #(
  parameter int length = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [length-1:0] rd_word,
  input  logic              byp_hit,
  input  logic [length-1:0] byp_data,
  output logic [length-1:0] outdata
);

  logic [length-1:0] next_word;

`ifdef TDPRAM_BYPASS_EN
  always_comb begin
    next_word = rd_word;
    if (byp_hit) next_word = byp_data;
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_hit, byp_data};

  always_comb begin
    next_word = rd_word;
  end
`endif

  // Output holds whenever the port is writing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outdata <= '0;
    end else if (rd_en) begin
      outdata <= next_word;
    end
  end

endmodule

// File: rtl/true_dual_port_ram.sv
// True dual-port RAM, single clock, read-first across ports by default;
// define TDPRAM_BYPASS_EN for write-first forwarding between ports.
module true_dual_port_ram
  import true_dual_port_ram_pkg::*;
#(
  parameter int length   = LENGTH_DEF,
  parameter int location = LOCATION_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  true_dual_port_ram_if.slave  bus
);

  localparam int AW = addr_width(location);

  logic [length-1:0] mem [location];

  logic a_w_ok, b_w_ok, a_r_ok, b_r_ok;
  logic a_we, b_we;
  logic [length-1:0] a_rd_word, b_rd_word;

  // Range checks only matter when location is not a power of two.
  generate
    if (location == (1 << AW)) begin : g_full_range
      assign a_w_ok = 1'b1;
      assign b_w_ok = 1'b1;
      assign a_r_ok = 1'b1;
      assign b_r_ok = 1'b1;
    end else begin : g_partial_range
      assign a_w_ok = int'(bus.a_w_addr) < location;
      assign b_w_ok = int'(bus.b_w_addr) < location;
      assign a_r_ok = int'(bus.a_r_addr) < location;
      assign b_r_ok = int'(bus.b_r_addr) < location;
    end
  endgenerate

  // Port A wins a same-address write collision; B's write is suppressed.
  assign a_we = (bus.a_rw == RW_WRITE) && a_w_ok;
  assign b_we = (bus.b_rw == RW_WRITE) && b_w_ok &&
                !(a_we && (bus.a_w_addr == bus.b_w_addr));

  assign a_rd_word = a_r_ok ? mem[bus.a_r_addr] : '0;
  assign b_rd_word = b_r_ok ? mem[bus.b_r_addr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < location; i++) mem[i] <= '0;
    end else begin
      if (a_we) mem[bus.a_w_addr] <= bus.a_indata;
      if (b_we) mem[bus.b_w_addr] <= bus.b_indata;
    end
  end

  tdpram_read_port #(.length(length)) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (bus.a_rw == RW_READ),
    .rd_word  (a_rd_word),
    .byp_hit  (b_we && (bus.b_w_addr == bus.a_r_addr) && a_r_ok),
    .byp_data (bus.b_indata),
    .outdata  (bus.a_outdata)
  );

  tdpram_read_port #(.length(length)) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (bus.b_rw == RW_READ),
    .rd_word  (b_rd_word),
    .byp_hit  (a_we && (bus.a_w_addr == bus.b_r_addr) && b_r_ok),
    .byp_data (bus.a_indata),
    .outdata  (bus.b_outdata)
  );

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Directed bench for true_dual_port_ram (default 8-bit x 16-word build);
// expectations switch with TDPRAM_BYPASS_EN.
module tb_true_dual_port_ram;
  import true_dual_port_ram_pkg::*;

  localparam int W = LENGTH_DEF;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  true_dual_port_ram_if #(.length(LENGTH_DEF), .location(LOCATION_DEF)) bus ();

  true_dual_port_ram #(.length(LENGTH_DEF), .location(LOCATION_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic rw, input logic [3:0] w_addr,
                         input logic [3:0] r_addr, input logic [W-1:0] data);
    bus.a_rw     = rw;
    bus.a_w_addr = w_addr;
    bus.a_r_addr = r_addr;
    bus.a_indata = data;
  endtask

  task automatic drive_b(input logic rw, input logic [3:0] w_addr,
                         input logic [3:0] r_addr, input logic [W-1:0] data);
    bus.b_rw     = rw;
    bus.b_w_addr = w_addr;
    bus.b_r_addr = r_addr;
    bus.b_indata = data;
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_a(RW_WRITE, 4'd5, 4'd0, 8'h77);
    drive_b(RW_READ, 4'd0, 4'd0, 8'h00);
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.a_outdata !== 8'h00) begin
      errors++; $display("FAIL reset_a_during: got %h expected %h", bus.a_outdata, 8'h00);
    end
    checks++;
    if (bus.b_outdata !== 8'h00) begin
      errors++; $display("FAIL reset_b_during: got %h expected %h", bus.b_outdata, 8'h00);
    end
    step();
    rst = 1'b0;
    drive_a(RW_READ, 4'd0, 4'd5, 8'h00);
    drive_b(RW_READ, 4'd0, 4'd5, 8'h00);
    step();
    checks++;
    if (bus.a_outdata !== 8'h00) begin
      errors++; $display("FAIL reset_read_a5: got %h expected %h", bus.a_outdata, 8'h00);
    end
    checks++;
    if (bus.b_outdata !== 8'h00) begin
      errors++; $display("FAIL reset_read_b5: got %h expected %h", bus.b_outdata, 8'h00);
    end
  endtask

  task automatic test_dual_write_read();
    drive_a(RW_WRITE, 4'd3, 4'd0, 8'hA5);
    drive_b(RW_WRITE, 4'd9, 4'd0, 8'h3C);
    step();
    drive_a(RW_READ, 4'd0, 4'd9, 8'h00);
    drive_b(RW_READ, 4'd0, 4'd3, 8'h00);
    step();
    checks++;
    if (bus.a_outdata !== 8'h3C) begin
      errors++; $display("FAIL dual_read_a9: got %h expected %h", bus.a_outdata, 8'h3C);
    end
    checks++;
    if (bus.b_outdata !== 8'hA5) begin
      errors++; $display("FAIL dual_read_b3: got %h expected %h", bus.b_outdata, 8'hA5);
    end
  endtask

  task automatic test_collision();
    drive_a(RW_WRITE, 4'd7, 4'd0, 8'h11);
    drive_b(RW_WRITE, 4'd7, 4'd0, 8'h22);
    step();
    drive_a(RW_READ, 4'd0, 4'd7, 8'h00);
    drive_b(RW_READ, 4'd0, 4'd7, 8'h00);
    step();
    checks++;
    if (bus.a_outdata !== 8'h11) begin
      errors++; $display("FAIL collision_a7: got %h expected %h", bus.a_outdata, 8'h11);
    end
    checks++;
    if (bus.b_outdata !== 8'h11) begin
      errors++; $display("FAIL collision_b7: got %h expected %h", bus.b_outdata, 8'h11);
    end
  endtask

  task automatic test_read_during_write();
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
`ifdef TDPRAM_BYPASS_EN
    exp_a = 8'h66;
    exp_b = 8'h99;
`else
    exp_a = 8'h55;
    exp_b = 8'h66;
`endif
    drive_a(RW_WRITE, 4'd4, 4'd0, 8'h55);
    drive_b(RW_READ, 4'd0, 4'd0, 8'h00);
    step();
    drive_a(RW_READ, 4'd0, 4'd4, 8'h00);
    drive_b(RW_WRITE, 4'd4, 4'd0, 8'h66);
    step();
    checks++;
    if (bus.a_outdata !== exp_a) begin
      errors++; $display("FAIL rdw_a_reads_b_writes: got %h expected %h", bus.a_outdata, exp_a);
    end
    drive_a(RW_READ, 4'd0, 4'd4, 8'h00);
    drive_b(RW_READ, 4'd0, 4'd4, 8'h00);
    step();
    checks++;
    if (bus.a_outdata !== 8'h66) begin
      errors++; $display("FAIL rdw_a_next_read: got %h expected %h", bus.a_outdata, 8'h66);
    end
    drive_a(RW_WRITE, 4'd4, 4'd0, 8'h99);
    drive_b(RW_READ, 4'd0, 4'd4, 8'h00);
    step();
    checks++;
    if (bus.b_outdata !== exp_b) begin
      errors++; $display("FAIL rdw_b_reads_a_writes: got %h expected %h", bus.b_outdata, exp_b);
    end
    drive_a(RW_READ, 4'd0, 4'd4, 8'h00);
    step();
    checks++;
    if (bus.b_outdata !== 8'h99) begin
      errors++; $display("FAIL rdw_b_next_read: got %h expected %h", bus.b_outdata, 8'h99);
    end
  endtask

  task automatic test_hold();
    logic [W-1:0] wdata [3] = '{8'hD1, 8'hD2, 8'hD3};
    drive_a(RW_READ, 4'd0, 4'd9, 8'h00);
    drive_b(RW_READ, 4'd0, 4'd0, 8'h00);
    step();
    checks++;
    if (bus.a_outdata !== 8'h3C) begin
      errors++; $display("FAIL hold_initial_read: got %h expected %h", bus.a_outdata, 8'h3C);
    end
    for (int i = 0; i < 3; i++) begin
      drive_a(RW_WRITE, 4'd0, 4'd3, wdata[i]);
      step();
      checks++;
      if (bus.a_outdata !== 8'h3C) begin
        errors++; $display("FAIL hold_cycle%0d: got %h expected %h", i, bus.a_outdata, 8'h3C);
      end
    end
    drive_a(RW_READ, 4'd0, 4'd0, 8'h00);
    step();
    checks++;
    if (bus.a_outdata !== 8'hD3) begin
      errors++; $display("FAIL hold_last_write: got %h expected %h", bus.a_outdata, 8'hD3);
    end
  endtask

  task automatic test_ignore_write_fields();
    drive_a(RW_READ, 4'd0, 4'd0, 8'hEE);
    drive_b(RW_READ, 4'd3, 4'd3, 8'hEE);
    step();
    step();
    checks++;
    if (bus.a_outdata !== 8'hD3) begin
      errors++; $display("FAIL ignore_wfields_a0: got %h expected %h", bus.a_outdata, 8'hD3);
    end
    checks++;
    if (bus.b_outdata !== 8'hA5) begin
      errors++; $display("FAIL ignore_wfields_b3: got %h expected %h", bus.b_outdata, 8'hA5);
    end
  endtask

  task automatic test_async_reset();
    drive_a(RW_READ, 4'd0, 4'd9, 8'h00);
    drive_b(RW_READ, 4'd0, 4'd3, 8'h00);
    step();
    checks++;
    if (bus.a_outdata !== 8'h3C || bus.b_outdata !== 8'hA5) begin
      errors++; $display("FAIL async_pre_reset: got %h/%h expected %h/%h",
                         bus.a_outdata, bus.b_outdata, 8'h3C, 8'hA5);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.a_outdata !== 8'h00) begin
      errors++; $display("FAIL async_a_immediate: got %h expected %h", bus.a_outdata, 8'h00);
    end
    checks++;
    if (bus.b_outdata !== 8'h00) begin
      errors++; $display("FAIL async_b_immediate: got %h expected %h", bus.b_outdata, 8'h00);
    end
    drive_a(RW_WRITE, 4'd6, 4'd0, 8'hAB);
    drive_b(RW_READ, 4'd0, 4'd3, 8'h00);
    step();
    checks++;
    if (bus.b_outdata !== 8'h00) begin
      errors++; $display("FAIL async_read_in_reset: got %h expected %h", bus.b_outdata, 8'h00);
    end
    rst = 1'b0;
    drive_a(RW_READ, 4'd0, 4'd6, 8'h00);
    drive_b(RW_READ, 4'd0, 4'd9, 8'h00);
    step();
    checks++;
    if (bus.a_outdata !== 8'h00) begin
      errors++; $display("FAIL async_write_ignored_a6: got %h expected %h", bus.a_outdata, 8'h00);
    end
    checks++;
    if (bus.b_outdata !== 8'h00) begin
      errors++; $display("FAIL async_cleared_b9: got %h expected %h", bus.b_outdata, 8'h00);
    end
    drive_b(RW_READ, 4'd0, 4'd3, 8'h00);
    step();
    checks++;
    if (bus.b_outdata !== 8'h00) begin
      errors++; $display("FAIL async_cleared_b3: got %h expected %h", bus.b_outdata, 8'h00);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive_a(RW_READ, 4'd0, 4'd0, 8'h00);
    drive_b(RW_READ, 4'd0, 4'd0, 8'h00);
    step();
    step();
    rst = 1'b0;
    step();

    test_reset();
    test_dual_write_read();
    test_collision();
    test_read_during_write();
    test_hold();
    test_ignore_write_fields();
    test_async_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/true_dual_port_ram.md
TRUE_DUAL_PORT_RAM -- requirements
Module: true_dual_port_ram

Interface
REQ-001 SHALL have parameter length, default 8, data word width in bits.
REQ-002 SHALL have parameter location, default 16, number of words; address width AW = $clog2(location).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port a_rw, input, 1, port A mode: 1 = write, 0 = read.
REQ-006 SHALL have port b_rw, input, 1, port B mode: 1 = write, 0 = read.
REQ-007 SHALL have ports a_w_addr and b_w_addr, input, AW, write addresses for ports A and B.
REQ-008 SHALL have ports a_r_addr and b_r_addr, input, AW, read addresses for ports A and B.
REQ-009 SHALL have ports a_indata and b_indata, input, length, write data for ports A and B.
REQ-010 SHALL have ports a_outdata and b_outdata, output, length, registered read data for ports A and B.

Function
REQ-011 SHALL store location words of length bits, with two fully independent ports A and B.
REQ-012 SHALL, for a port with rw=1 at a rising clk edge, write that port's indata to mem[w_addr].
REQ-013 SHALL, for a port with rw=0 at a rising clk edge, load that port's outdata with mem[r_addr]; read latency is exactly 1 cycle.
REQ-014 SHALL hold a port's outdata unchanged in every cycle where that port has rw=1.
REQ-015 SHALL ignore r_addr while its port writes, and ignore w_addr/indata while its port reads.
REQ-016 SHALL, when both ports write the same address in one cycle, store a_indata (port A wins) and discard b_indata.
REQ-017 SHALL, when both ports write different addresses in one cycle, perform both writes.
REQ-018 SHALL, when one port reads an address the other port writes in the same cycle, return the old stored word (read-first), unless TDPRAM_BYPASS_EN is defined.
REQ-019 SHALL allow both ports to read the same or different addresses simultaneously with no interaction.
REQ-020 SHALL truncate nothing: addresses are AW bits; when location is not a power of two, out-of-range writes SHALL be dropped and out-of-range reads SHALL return 0.

Reset
REQ-021 SHALL, while rst=1, force a_outdata and b_outdata to 0 and clear every memory word to 0, asynchronously.
REQ-022 SHALL ignore all writes and reads in any cycle where rst=1 at the clock edge; normal operation resumes on the first rising edge after rst deasserts.
REQ-023 SHALL abort an in-flight read if rst asserts mid-cycle; the output stays 0.

Configuration
REQ-024 SHALL, with macro TDPRAM_BYPASS_EN defined, forward the other port's same-cycle write data to a reading port whose r_addr equals the other port's w_addr (write-first across ports).
REQ-025 SHALL, without TDPRAM_BYPASS_EN, behave read-first as in REQ-018; all other behaviour is identical in both builds.

Structure
REQ-026 SHALL take default parameter values (LENGTH_DEF=8, LOCATION_DEF=16) and the rw encoding constants (RW_READ=0, RW_WRITE=1) from shared package true_dual_port_ram_pkg.
REQ-027 SHALL implement each port's read/output register and bypass mux in one sub-module, tdpram_read_port, instantiated twice; the array and collision arbitration stay in the top level.

Verification
REQ-028 SHALL verify reset: after rst pulse, read addr 5 on both ports -> a_outdata=b_outdata=0 one cycle later.
REQ-029 SHALL verify dual write/read: A writes 0xA5@3, B writes 0x3C@9; next cycle both read (A@9, B@3) -> a_outdata=0x3C, b_outdata=0xA5 after 1 cycle.
REQ-030 SHALL verify write collision: A writes 0x11@7 and B writes 0x22@7 in the same cycle; later read of 7 -> 0x11.
REQ-031 SHALL verify cross-port read-during-write: mem[4]=0x55; A reads 4 while B writes 0x66@4 -> a_outdata=0x55 (0x66 with TDPRAM_BYPASS_EN); next read -> 0x66.
REQ-032 SHALL verify hold: A reads 0x3C, then A switches to write for 3 cycles -> a_outdata stays 0x3C throughout.
REQ-033 SHALL verify async reset mid-operation: assert rst between edges during reads -> outputs 0 immediately, and previously written words read back as 0.
